nibble_serial_adder: RTL and testbench
======================================

Name: nibble_serial_adder

Overview:
- Sequencing stage wrapped around the team's existing 4-bit carry-lookahead adder cell (ports A, B, carryin, Y, carryout).
- Accepts wide operands over a valid/ready handshake and feeds the CLA cell one nibble per clock, LSB first, with the carry held in a register.
- Collects the cell's Y/carryout into a wide result, then presents it downstream over a second valid/ready handshake.
- Used where a full-width CLA is too large and a multi-cycle add is acceptable.

Parameters:
- NIBBLES, 4: number of 4-bit slices. Operand width W = 4*NIBBLES. Legal range 1..16.

Ports:
- clk  in  1  rising-edge clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  operands valid.
- in_ready  out  1  block can accept operands.
- a  in  W  operand A.
- b  in  W  operand B.
- cin  in  1  carry into bit 0.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- sum  out  W  result.
- cout  out  1  carry out of bit W-1.
- ovf  out  1  two's-complement overflow.
- busy  out  1  high in RUN or DONE.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on reset, sampled on the clk rising edge.
- Reset values: state=IDLE; in_ready=1; out_valid=0; busy=0; sum=0; cout=0; ovf=0; nibble counter=0; carry register=0; operand shift registers=0.
- FSM has three states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: latch a and b into shift registers, load carry register with cin, clear counter, capture a[W-1] and b[W-1] for ovf, go to RUN.
- RUN:
  - in_ready=0.
  - Each cycle, drive the CLA with A=areg[3:0], B=breg[3:0], carryin=carry register.
  - At the edge: shift areg and breg right by 4; shift Y into the top nibble of the sum shift register (sum shifts right by 4); carry register <= carryout; counter++.
  - When counter reaches NIBBLES-1 at that edge, go to DONE.
  - RUN lasts exactly NIBBLES cycles.
- DONE:
  - out_valid=1.
  - sum, cout and ovf are stable and held while out_ready=0.
  - On out_ready=1: out_valid drops at the next edge and the FSM returns to IDLE.
  - in_ready=0 throughout DONE, so no back-to-back accept in the same cycle.
- Latency: handshake accepted at edge k, out_valid high after edge k+NIBBLES. Minimum throughput is one operation per NIBBLES+2 cycles.
- Result fields:
  - cout is the final carry register.
  - ovf = a_msb ^ b_msb ^ sum[W-1] ^ cout (equivalent to carry into the MSB xor carry out).
- Outputs sum, cout and ovf update only on entry to DONE. They hold their last values through IDLE and RUN; during RUN the internal shift register is not visible on sum.
- Reset asserted in any state, including mid-RUN, restores all reset values at that edge. The partial result is discarded and no out_valid is produced.
- in_valid while in RUN or DONE is ignored; the source must hold its data until in_ready.
- NIBBLES=1: RUN lasts one cycle; behaviour is otherwise identical.
- Width rule: arithmetic is modulo 2^W, with the carry out reported on cout.

Optional Feature:
- Macro: NIBBLE_SERIAL_ADDER_SUB_EN.
- With the macro defined:
  - Extra input port sub (1 bit), sampled at the in_valid&in_ready handshake.
  - When sub=1: breg is loaded with ~b and the carry register with 1 (cin ignored), so sum = a - b mod 2^W.
  - cout=1 means no borrow.
  - ovf uses the inverted b MSB.
- Without the macro: no sub port; the block is add-only.

Test Plan:
- Basic add, NIBBLES=4: a=0x1234, b=0x4321, cin=0 -> after 4 RUN cycles, out_valid=1 with sum=0x5555, cout=0, ovf=0.
- Carry ripple across all slices: a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1, ovf=0. Separately, a=0x0000, b=0xFFFF, cin=1 -> sum=0x0000, cout=1.
- Signed overflow: a=0x7FFF, b=0x0001 -> sum=0x8000, cout=0, ovf=1. Separately, a=0x8000, b=0x8000 -> sum=0x0000, cout=1, ovf=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE while driving in_valid=1 with new operands -> sum, cout, ovf and out_valid stay stable, in_ready=0, nothing accepted. Then out_ready=1 -> IDLE next cycle, and the new operands are accepted on the following edge.
- Reset mid-operation: assert reset for 1 cycle after 2 RUN cycles of 0x1234+0x4321 -> every output returns to its reset value and out_valid never pulses. A following 0x0F0F+0x00F1 -> sum=0x1000, cout=0.
- NIBBLE_SERIAL_ADDER_SUB_EN defined: a=0x0005, b=0x0007, sub=1 -> sum=0xFFFE, cout=0, ovf=0. Separately, a=0x8000, b=0x0001, sub=1 -> sum=0x7FFF, cout=1, ovf=1.

Source files
------------

// File: rtl/nibble_serial_adder.sv
// Multi-cycle adder: feeds a 4-bit carry-lookahead cell one nibble per clock, LSB first.
// Define NIBBLE_SERIAL_ADDER_SUB_EN to add a 'sub' input (a - b via inverted b and carry-in 1).

module cla4_cell (
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       carryin,
    output logic [3:0] Y,
    output logic       carryout
);
    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;

    assign g = A & B;
    assign p = A ^ B;

    // Carries expanded two-level so no carry ripples through the cell
    assign c[0] = carryin;
    assign c[1] = g[0] | (p[0] & carryin);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & carryin);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & carryin);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & carryin);

    assign Y        = p ^ c[3:0];
    assign carryout = c[4];
endmodule

// state | meaning
// IDLE  | waiting for operands, in_ready=1
// RUN   | one nibble added per clock, NIBBLES cycles
// DONE  | result presented, held until out_ready
module nibble_serial_adder #(
    parameter int NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [4*NIBBLES-1:0] a,
    input  logic [4*NIBBLES-1:0] b,
    input  logic                 cin,
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
    input  logic                 sub,
`endif
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [4*NIBBLES-1:0] sum,
    output logic                 cout,
    output logic                 ovf,
    output logic                 busy
);
    localparam int W  = 4 * NIBBLES;
    localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state;
    state_t        state_nx;
    logic [W-1:0]  areg;
    logic [W-1:0]  breg;
    logic [W-1:0]  sreg;
    logic [W-1:0]  sreg_nx;
    logic          carry;
    logic [CW-1:0] cnt;
    logic          a_msb;
    logic          b_msb;
    logic          last;
    logic [W-1:0]  b_eff;
    logic          cin_eff;
    logic [3:0]    cla_y;
    logic          cla_co;

`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
    assign b_eff   = sub ? ~b : b;
    assign cin_eff = sub ? 1'b1 : cin;
`else
    assign b_eff   = b;
    assign cin_eff = cin;
`endif

    cla4_cell u_cla (
        .A        (areg[3:0]),
        .B        (breg[3:0]),
        .carryin  (carry),
        .Y        (cla_y),
        .carryout (cla_co)
    );

    assign last = (cnt == CW'(NIBBLES - 1));
    // New nibble enters at the top; after NIBBLES shifts the LSB nibble sits at bit 0
    assign sreg_nx = (sreg >> 4) | (W'(cla_y) << (W - 4));

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (in_valid) state_nx = RUN;
            RUN:     if (last)     state_nx = DONE;
            DONE:    if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
        busy      = (state != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            areg  <= '0;
            breg  <= '0;
            sreg  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            a_msb <= 1'b0;
            b_msb <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        areg  <= a;
                        breg  <= b_eff;
                        carry <= cin_eff;
                        cnt   <= '0;
                        a_msb <= a[W-1];
                        b_msb <= b_eff[W-1];
                    end
                end
                RUN: begin
                    areg  <= areg >> 4;
                    breg  <= breg >> 4;
                    sreg  <= sreg_nx;
                    carry <= cla_co;
                    cnt   <= cnt + CW'(1);
                    if (last) begin
                        sum  <= sreg_nx;
                        cout <= cla_co;
                        ovf  <= a_msb ^ b_msb ^ sreg_nx[W-1] ^ cla_co;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench for nibble_serial_adder: directed cases plus random operands
// against a plain-arithmetic reference model.

module tb_nibble_serial_adder;
    localparam int NIBBLES = 4;
    localparam int W = 4 * NIBBLES;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
    logic         sub;
`endif
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         busy;

    int errors = 0;
    int checks = 0;

    nibble_serial_adder #(.NIBBLES(NIBBLES)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
        .sub       (sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain (W+1)-bit addition; subtraction as a + ~b + 1
    task automatic model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c,
                         input logic s, output logic [W-1:0] es, output logic ec,
                         output logic eo);
        logic [W:0] full;
        if (s) full = {1'b0, x} + {1'b0, ~y} + (W+1)'(1);
        else   full = {1'b0, x} + {1'b0, y} + (W+1)'(c);
        es = full[W-1:0];
        ec = full[W];
        if (s) eo = (x[W-1] != y[W-1]) && (es[W-1] != x[W-1]);
        else   eo = (x[W-1] == y[W-1]) && (es[W-1] != x[W-1]);
    endtask

    task automatic start_op(input logic [W-1:0] x, input logic [W-1:0] y,
                            input logic c, input logic s);
        @(negedge clk);
        a = x;
        b = y;
        cin = c;
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
        sub = s;
`else
        if (s) $display("note: sub requested without subtract build");
`endif
        in_valid = 1'b1;
        check("in_ready_before_accept", in_ready, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        check("busy_after_accept", busy, 1'b1);
    endtask

    task automatic wait_result(input logic [W-1:0] es, input logic ec, input logic eo);
        int n = 0;
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("latency", n, NIBBLES);
        check("sum", sum, es);
        check("cout", cout, ec);
        check("ovf", ovf, eo);
        check("in_ready_in_done", in_ready, 1'b0);
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("out_valid_after_release", out_valid, 1'b0);
        check("in_ready_after_release", in_ready, 1'b1);
    endtask

    task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic c, input logic s);
        logic [W-1:0] es;
        logic ec, eo;
        model(x, y, c, s, es, ec, eo);
        start_op(x, y, c, s);
        wait_result(es, ec, eo);
        release_result();
    endtask

    initial begin
        logic [W-1:0] rx, ry, hs;
        logic rc, rs, hc, ho;

        reset = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        a = '0;
        b = '0;
        cin = 1'b0;
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
        sub = 1'b0;
`endif
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check("reset_in_ready", in_ready, 1'b1);
        check("reset_out_valid", out_valid, 1'b0);
        check("reset_busy", busy, 1'b0);
        check("reset_sum", sum, 0);
        check("reset_cout", cout, 1'b0);
        check("reset_ovf", ovf, 1'b0);

        // Directed cases with spec-given results
        start_op(16'h1234, 16'h4321, 1'b0, 1'b0);
        wait_result(16'h5555, 1'b0, 1'b0);
        release_result();
        start_op(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        wait_result(16'h0000, 1'b1, 1'b0);
        release_result();
        start_op(16'h0000, 16'hFFFF, 1'b1, 1'b0);
        wait_result(16'h0000, 1'b1, 1'b0);
        release_result();
        start_op(16'h7FFF, 16'h0001, 1'b0, 1'b0);
        wait_result(16'h8000, 1'b0, 1'b1);
        release_result();
        start_op(16'h8000, 16'h8000, 1'b0, 1'b0);
        wait_result(16'h0000, 1'b1, 1'b1);
        release_result();

        // Backpressure with a new request waiting
        start_op(16'h1234, 16'h4321, 1'b0, 1'b0);
        wait_result(16'h5555, 1'b0, 1'b0);
        a = 16'h0F0F;
        b = 16'h00F1;
        cin = 1'b0;
        in_valid = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("bp_out_valid", out_valid, 1'b1);
            check("bp_in_ready", in_ready, 1'b0);
            check("bp_sum", sum, 16'h5555);
            check("bp_cout", cout, 1'b0);
            check("bp_ovf", ovf, 1'b0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("bp_idle_out_valid", out_valid, 1'b0);
        check("bp_idle_in_ready", in_ready, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        check("bp_accept_busy", busy, 1'b1);
        wait_result(16'h1000, 1'b0, 1'b0);
        release_result();

        // Reset in the middle of RUN
        start_op(16'h1234, 16'h4321, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("mid_reset_in_ready", in_ready, 1'b1);
        check("mid_reset_out_valid", out_valid, 1'b0);
        check("mid_reset_busy", busy, 1'b0);
        check("mid_reset_sum", sum, 0);
        check("mid_reset_cout", cout, 1'b0);
        check("mid_reset_ovf", ovf, 1'b0);
        repeat (NIBBLES + 2) begin
            @(negedge clk);
            check("mid_reset_no_valid", out_valid, 1'b0);
        end
        start_op(16'h0F0F, 16'h00F1, 1'b0, 1'b0);
        wait_result(16'h1000, 1'b0, 1'b0);
        release_result();

`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
        start_op(16'h0005, 16'h0007, 1'b1, 1'b1);
        wait_result(16'hFFFE, 1'b0, 1'b0);
        release_result();
        start_op(16'h8000, 16'h0001, 1'b0, 1'b1);
        wait_result(16'h7FFF, 1'b1, 1'b1);
        release_result();
`endif

        // Random operands against the model
        for (int i = 0; i < 24; i++) begin
            rx = W'($urandom);
            ry = W'($urandom);
            rc = 1'($urandom_range(0, 1));
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
            rs = 1'($urandom_range(0, 1));
`else
            rs = 1'b0;
`endif
            run_op(rx, ry, rc, rs);
        end

        // Model sanity on one hand-computed point
        model(16'h7FFF, 16'h0001, 1'b0, 1'b0, hs, hc, ho);
        check("model_self_ovf", {hs, hc, ho}, {16'h8000, 1'b0, 1'b1});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
